// File: rtl/iq_unpacker.sv
// Assembles little-endian interleaved I/Q byte pairs into sign-extended, quantized samples.
// Optional `IQ_SAMPLE_COUNT_EN adds a 32-bit count of completed I/Q writes.
module iq_unpacker #(
  parameter int BYTE_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int QUANT_BITS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BYTE_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] i_out_din,
  input  logic                  i_out_full,
  output logic                  i_out_wr_en,
  output logic [DATA_WIDTH-1:0] q_out_din,
  input  logic                  q_out_full,
  output logic                  q_out_wr_en
`ifdef IQ_SAMPLE_COUNT_EN
  ,
  output logic [31:0]           sample_count
`endif
);

  typedef enum logic {S_READ, S_WRITE} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [4*BYTE_WIDTH-1:0]   asm_q, asm_d;
  logic [DATA_WIDTH-1:0]     i_ext, q_ext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_READ;
      cnt_q   <= 2'd0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
    end
  end

  // Enables are gated by reset so nothing is popped or written while it is held.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    in_rd_en    = 1'b0;
    i_out_wr_en = 1'b0;
    q_out_wr_en = 1'b0;
    case (state_q)
      S_READ: begin
        in_rd_en = !in_empty && !reset;
        if (in_rd_en) begin
          asm_d[cnt_q*BYTE_WIDTH +: BYTE_WIDTH] = in_dout;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        i_out_wr_en = !i_out_full && !q_out_full && !reset;
        q_out_wr_en = i_out_wr_en;
        if (i_out_wr_en) state_d = S_READ;
      end
      default: state_d = S_READ;
    endcase
  end

  assign i_ext = {{(DATA_WIDTH-16){asm_q[15]}}, asm_q[15:0]};
  assign q_ext = {{(DATA_WIDTH-16){asm_q[31]}}, asm_q[31:16]};

  assign i_out_din = (state_q == S_WRITE) ? (i_ext << QUANT_BITS) : '0;
  assign q_out_din = (state_q == S_WRITE) ? (q_ext << QUANT_BITS) : '0;

`ifdef IQ_SAMPLE_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= 32'd0;
    else if (i_out_wr_en) count_q <= count_q + 32'd1;
  end

  assign sample_count = count_q;
`endif

endmodule

// File: tb/tb_iq_unpacker.sv
// Directed vector table, multi-cycle corner sequences and a randomized stream for iq_unpacker.
module tb_iq_unpacker;

  logic        clock;
  logic        reset;
  logic [7:0]  in_dout;
  logic        in_empty;
  logic        in_rd_en;
  logic [31:0] i_out_din;
  logic        i_out_full;
  logic        i_out_wr_en;
  logic [31:0] q_out_din;
  logic        q_out_full;
  logic        q_out_wr_en;
`ifdef IQ_SAMPLE_COUNT_EN
  logic [31:0] sample_count;
`endif

  int tests = 0;
  int fails = 0;

  iq_unpacker #(.BYTE_WIDTH(8), .DATA_WIDTH(32), .QUANT_BITS(10)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_dout     (in_dout),
    .in_empty    (in_empty),
    .in_rd_en    (in_rd_en),
    .i_out_din   (i_out_din),
    .i_out_full  (i_out_full),
    .i_out_wr_en (i_out_wr_en),
    .q_out_din   (q_out_din),
    .q_out_full  (q_out_full),
    .q_out_wr_en (q_out_wr_en)
`ifdef IQ_SAMPLE_COUNT_EN
    ,
    .sample_count(sample_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_i, exp_q;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Tasks are entered 1 time unit after a rising edge and return at the same phase.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_dout  = b;
    in_empty = 1'b0;
    @(negedge clock);
    chk("pop_rd_en", {31'd0, in_rd_en}, 32'd1);
    chk("pop_no_wr", {31'd0, i_out_wr_en}, 32'd0);
    next_cycle();
    in_empty = 1'b1;
  endtask

  task automatic check_write(input string name, input logic [31:0] ei, input logic [31:0] eq);
    @(negedge clock);
    chk({name, "_wr_en"}, {30'd0, i_out_wr_en, q_out_wr_en}, 32'd3);
    chk({name, "_i"}, i_out_din, ei);
    chk({name, "_q"}, q_out_din, eq);
    next_cycle();
    @(negedge clock);
    chk({name, "_wr_once"}, {30'd0, i_out_wr_en, q_out_wr_en}, 32'd0);
    chk({name, "_i_idle"}, i_out_din, 32'd0);
    next_cycle();
  endtask

  function automatic logic [31:0] quant(input logic [7:0] lo, input logic [7:0] hi);
    logic signed [31:0] v;
    v = $signed({hi, lo});
    return v * 32'sd1024;
  endfunction

  vec_t vecs[4];
  logic [7:0]  src[$];
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_q_q[$];

  initial begin
    vecs[0] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 32'h0048D000, 32'hFEAF3400};
    vecs[1] = '{8'hFF, 8'h7F, 8'h00, 8'h80, 32'h01FFFC00, 32'hFE000000};
    vecs[2] = '{8'h00, 8'h80, 8'h00, 8'h00, 32'hFE000000, 32'h00000000};
    vecs[3] = '{8'hFF, 8'hFF, 8'h01, 8'h00, 32'hFFFFFC00, 32'h00000400};

    reset = 1'b1; in_dout = 8'h5A; in_empty = 1'b0;
    i_out_full = 1'b0; q_out_full = 1'b0;
    @(negedge clock);
    chk("reset_rd_en", {31'd0, in_rd_en}, 32'd0);
    chk("reset_wr_en", {30'd0, i_out_wr_en, q_out_wr_en}, 32'd0);
    chk("reset_i", i_out_din, 32'd0);
    chk("reset_q", q_out_din, 32'd0);
`ifdef IQ_SAMPLE_COUNT_EN
    chk("reset_count", sample_count, 32'd0);
`endif
    in_empty = 1'b1;
    next_cycle();
    reset = 1'b0;
    next_cycle();

    for (int k = 0; k < 4; k++) begin
      push_byte(vecs[k].b0);
      push_byte(vecs[k].b1);
      push_byte(vecs[k].b2);
      push_byte(vecs[k].b3);
      check_write($sformatf("vec%0d", k), vecs[k].exp_i, vecs[k].exp_q);
    end

    // Gap of 7 empty cycles between byte 2 and byte 3.
    push_byte(8'h34); push_byte(8'h12); push_byte(8'hCD);
    for (int g = 0; g < 7; g++) begin
      @(negedge clock);
      chk("gap_rd_en", {30'd0, in_rd_en, i_out_wr_en}, 32'd0);
      next_cycle();
    end
    push_byte(8'hAB);
    check_write("gap", 32'h0048D000, 32'hFEAF3400);

    // Q FIFO full for 10 cycles with a byte waiting upstream.
    push_byte(8'hFF); push_byte(8'h7F); push_byte(8'h00);
    q_out_full = 1'b1;
    push_byte(8'h80);
    for (int g = 0; g < 10; g++) begin
      in_dout = 8'h99; in_empty = 1'b0;
      @(negedge clock);
      chk("bp_blocked", {29'd0, in_rd_en, i_out_wr_en, q_out_wr_en}, 32'd0);
      chk("bp_i_stable", i_out_din, 32'h01FFFC00);
      next_cycle();
    end
    in_empty = 1'b1;
    q_out_full = 1'b0;
    check_write("bp", 32'h01FFFC00, 32'hFE000000);

    // Reset in the middle of a sample discards the partial bytes.
    push_byte(8'h11); push_byte(8'h22);
    reset = 1'b1; in_dout = 8'h77; in_empty = 1'b0;
    @(negedge clock);
    chk("midrst_outs", {29'd0, in_rd_en, i_out_wr_en, q_out_wr_en}, 32'd0);
    chk("midrst_i", i_out_din | q_out_din, 32'd0);
    next_cycle();
    reset = 1'b0; in_empty = 1'b1;
    next_cycle();
    push_byte(8'h34); push_byte(8'h12); push_byte(8'hCD); push_byte(8'hAB);
    check_write("midrst", 32'h0048D000, 32'hFEAF3400);

    // Randomized stream with input gaps and output backpressure.
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int s = 0; s < 1000; s++) begin
      logic [7:0] b[4];
      for (int j = 0; j < 4; j++) begin
        b[j] = 8'($urandom);
        src.push_back(b[j]);
      end
      exp_i_q.push_back(quant(b[0], b[1]));
      exp_q_q.push_back(quant(b[2], b[3]));
    end
    begin
      int cyc = 0;
      int got = 0;
      logic popped;
      in_empty = 1'b0; in_dout = src[0];
      while (exp_i_q.size() > 0 && cyc < 40000) begin
        @(negedge clock);
        popped = in_rd_en;
        if (in_rd_en) chk("st_rd_empty", {31'd0, in_empty}, 32'd0);
        if (i_out_wr_en || q_out_wr_en) begin
          chk("st_wr_atomic", {30'd0, i_out_wr_en, q_out_wr_en}, 32'd3);
          chk("st_wr_full", {30'd0, i_out_full, q_out_full}, 32'd0);
          chk($sformatf("st_i%0d", got), i_out_din, exp_i_q.pop_front());
          chk($sformatf("st_q%0d", got), q_out_din, exp_q_q.pop_front());
          got++;
        end
        next_cycle();
        if (popped && src.size() > 0) void'(src.pop_front());
        in_empty   = (src.size() == 0) || ($urandom_range(0, 3) == 0);
        in_dout    = (src.size() > 0) ? src[0] : 8'h00;
        i_out_full = ($urandom_range(0, 3) == 0);
        q_out_full = ($urandom_range(0, 3) == 0);
        cyc++;
      end
      chk("st_remaining", exp_i_q.size(), 32'd0);
      chk("st_samples", got, 32'd1000);
      chk("st_src_drained", src.size(), 32'd0);
    end
    i_out_full = 1'b0; q_out_full = 1'b0; in_empty = 1'b1;
    @(negedge clock);
`ifdef IQ_SAMPLE_COUNT_EN
    chk("st_count", sample_count, 32'd1000);
`endif
    chk("st_idle", {29'd0, in_rd_en, i_out_wr_en, q_out_wr_en}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
